// File: rtl/sound_output.sv
// sound_output: AHB-Lite slave that plays queued notes as a square wave.
//   The CPU writes NOTE words {duration[31:16], half_period[15:0]} into a small
//   FIFO. An IDLE/LOAD/PLAY FSM pops the notes and plays them back-to-back.
//   Ports: HCLK/HRESET (sync, active-high); AHB-Lite slave inputs HADDR, HWDATA,
//   HSIZE (ignored), HTRANS, HWRITE, HREADY, HSEL; outputs HRDATA (STATUS only),
//   HREADYOUT (tied 1), speaker (audio square wave), busy (note in LOAD/PLAY).
//   Map: 0x0 NOTE (W), 0x4 STATUS (R), 0x8 CTRL (W: [0] flush, [1] clr_overflow).
module sound_output #(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        speaker,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t         state, state_nxt;
  logic           wr_en, rd_en;
  logic [1:0]     addr;
  logic           push, flush, clr_ovf, pop, drop, do_push, full, empty;
  logic           overflow;
  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic [31:0]    note;
  logic [15:0]    half_cnt, dur_cnt;
  logic [TW-1:0]  tick_cnt;
  logic           tick_wrap;
  logic           unused;

  assign HREADYOUT = 1'b1;
  assign unused    = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

  // Address phase capture; the data phase acts on these one cycle later.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      addr  <= 2'd0;
    end else begin
      wr_en <= HSEL && HREADY && (HTRANS != 2'b00) && HWRITE;
      rd_en <= HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE;
      addr  <= HADDR[3:2];
    end
  end

  assign push    = wr_en && (addr == 2'd0);
  assign flush   = wr_en && (addr == 2'd2) && HWDATA[0];
  assign clr_ovf = wr_en && (addr == 2'd2) && HWDATA[1];
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign drop    = push && full && !pop && !flush;
  assign do_push = push && !drop && !flush;

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= HWDATA;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new overflow outranks a simultaneous clear.
  always_ff @(posedge HCLK) begin
    if (HRESET)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET || flush) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) state_nxt = LOAD;
      LOAD: state_nxt = (note[31:16] == 16'd0) ? IDLE : PLAY;
      PLAY: if (tick_wrap && dur_cnt <= 16'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    pop  = (state == IDLE) && !empty && !flush;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || flush) begin
      note     <= '0;
      half_cnt <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
      speaker  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) note <= mem[rd_ptr];
        LOAD: begin
          half_cnt <= note[15:0];
          dur_cnt  <= note[31:16];
          tick_cnt <= '0;
          speaker  <= 1'b0;
        end
        PLAY: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            dur_cnt  <= dur_cnt - 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          // half_period 0 is a rest: the counter is left alone, speaker stays low.
          if (note[15:0] != 16'd0) begin
            if (half_cnt == 16'd1) begin
              speaker  <= ~speaker;
              half_cnt <= note[15:0];
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end else begin
            speaker <= 1'b0;
          end
          if (tick_wrap && dur_cnt <= 16'd1) speaker <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en && addr == 2'd1)
      HRDATA = {24'd0, 4'(count), overflow, empty, full, busy};
  end

endmodule

// File: tb/tb_sound_output.sv
module tb_sound_output;
  localparam int DEPTH = 4;
  localparam int TD    = 10;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HRDATA;
  logic        HREADYOUT, speaker, busy;

  always #5 HCLK = ~HCLK;

  sound_output #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .speaker(speaker), .busy(busy)
  );

  typedef struct {
    logic        bsy;
    logic        spk;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: a queue of pending notes plus the start cycle of the
  // note being played; outputs follow from elapsed time since that start.
  logic [31:0] mq[$];
  bit          m_ovf = 0, m_active = 0;
  int          m_load = 0, m_hp = 0, m_dur = 0;
  bit          dp_wr = 0, dp_rd = 0;
  logic [1:0]  dp_addr = 2'd0;

  initial begin : model
    forever begin
      @(posedge HCLK);
      begin
        automatic bit   idle, push, flush, clr, pop, drop;
        automatic int   rel;
        automatic exp_t e;
        automatic logic [31:0] n, st;
        if (HRESET) begin
          mq.delete();
          m_ovf = 0; m_active = 0; dp_wr = 0; dp_rd = 0; dp_addr = 2'd0;
        end else begin
          idle  = !m_active || ((cyc - m_load) > m_dur * TD);
          push  = dp_wr && dp_addr == 2'd0;
          flush = dp_wr && dp_addr == 2'd2 && HWDATA[0];
          clr   = dp_wr && dp_addr == 2'd2 && HWDATA[1];
          if (flush) begin
            mq.delete();
            m_active = 0;
            if (clr) m_ovf = 0;
          end else begin
            pop  = idle && mq.size() > 0;
            drop = push && mq.size() == DEPTH && !pop;
            if (pop) begin
              n = mq.pop_front();
              m_hp = int'(n[15:0]); m_dur = int'(n[31:16]);
              m_active = 1; m_load = cyc + 1;
            end else if (idle) begin
              m_active = 0;
            end
            if (push && !drop) mq.push_back(HWDATA);
            if (clr)  m_ovf = 0;
            if (drop) m_ovf = 1;
          end
          dp_wr   = HSEL && HREADY && HTRANS != 2'b00 && HWRITE;
          dp_rd   = HSEL && HREADY && HTRANS != 2'b00 && !HWRITE;
          dp_addr = HADDR[3:2];
        end
        cyc++;
        rel   = cyc - m_load;
        e.bsy = m_active && rel <= m_dur * TD;
        e.spk = e.bsy && rel >= 1 && m_hp != 0 && (((rel - 1) / m_hp) % 2 == 1);
        st    = {24'd0, 4'(mq.size()), m_ovf, mq.size() == 0, mq.size() == DEPTH, e.bsy};
        e.rdata = (dp_rd && dp_addr == 2'd1) ? st : 32'd0;
        exp_q.push_back(e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", {31'd0, busy}, {31'd0, e.bsy});
        chk("speaker", {31'd0, speaker}, {31'd0, e.spk});
        chk("hrdata", HRDATA, e.rdata);
        chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      end
    end
  end

  task automatic bus(input bit write, input logic [1:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    HWRITE = write; HSIZE = 3'($urandom);
    HADDR = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    bus(1'b0, a, $urandom());
  endtask

  // Cycles with no transfer, in varied forms (unselected, HTRANS idle, HREADY low).
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge HCLK);
      HADDR = $urandom(); HWRITE = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       begin HSEL = 1'b0; HTRANS = 2'b10; HREADY = 1'b1; end
        1:       begin HSEL = 1'b1; HTRANS = 2'b00; HREADY = 1'b1; end
        default: begin HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b0; end
      endcase
    end
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
  endtask

  initial begin : stimulus
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    idle(2);
    rd(2'd1);                              // status after reset: empty only

    wr(2'd0, 32'h0002_0003);               // basic note
    idle(26);

    wr(2'd0, 32'h0003_0002);               // long note, then overfill FIFO
    idle(3);
    for (int i = 0; i < 5; i++) wr(2'd0, {16'd1, 16'(i + 1)});
    rd(2'd1);
    wr(2'd2, 32'h0000_0002);               // clear overflow
    rd(2'd1);
    wr(2'd2, 32'h0000_0001);               // flush remainder
    rd(2'd1);
    idle(3);

    wr(2'd0, 32'h0001_0000);               // rest note
    idle(15);
    wr(2'd0, 32'h0000_0004);               // zero duration
    idle(5);

    wr(2'd0, 32'h0003_0002);               // flush mid-note
    idle(8);
    wr(2'd2, 32'h0000_0001);
    rd(2'd1);
    idle(3);

    wr(2'd0, 32'h0003_0002);               // reset mid-note
    wr(2'd0, 32'h0001_0001);
    idle(8);
    @(negedge HCLK); HRESET = 1'b1;
    @(negedge HCLK); HRESET = 1'b0;
    rd(2'd1);
    idle(3);

    wr(2'd0, 32'h0001_0002);               // back-to-back notes
    wr(2'd0, 32'h0001_0005);
    rd(2'd1);
    idle(30);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(2'd0, {16'($urandom_range(0, 2)), 16'($urandom_range(0, 4))});
        4:          wr(2'd2, {30'($urandom), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 5) == 0)});
        5:          wr(2'($urandom_range(1, 3) | 1), $urandom());
        6, 7:       rd(2'($urandom));
        default:    idle($urandom_range(0, 6));
      endcase
    end
    wr(2'd2, 32'h0000_0003);
    rd(2'd1);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
